// File: rtl/ula_pkg.sv
// Shared ULA definitions: opcodes, flag bit positions and the dispatcher FSM encoding.
// Also used by the ULA and the control unit, so values here must not drift.
package ula_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_OVF   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_NEG   = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Assemble the 4-bit flag word; bit order comes from the FLG_* indices.
    function automatic logic [3:0] pack_flags(input logic zero, input logic ovf,
                                              input logic carry, input logic neg);
        logic [3:0] f;
        f            = '0;
        f[FLG_ZERO]  = zero;
        f[FLG_OVF]   = ovf;
        f[FLG_CARRY] = carry;
        f[FLG_NEG]   = neg;
        return f;
    endfunction

endpackage

// File: rtl/ula_dispatch.sv
// Initiator side of the ULA operand/result interface: holds operands for ULA_LAT cycles,
// captures result and flags, and returns them over a valid/ready response port.
module ula_dispatch
    import ula_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPW     = 5,
    parameter int ULA_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic [WIDTH-1:0] ula_A,
    output logic [WIDTH-1:0] ula_B,
    output logic [OPW-1:0]   ula_opcode,
    input  logic [WIDTH-1:0] ula_out,
    input  logic             ula_zero,
    input  logic             ula_overflow,
    input  logic             ula_carry,
    input  logic             ula_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       status_flags,
    output logic             busy
);

    localparam int CNTW = 4;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ULA_LAT - 1);

    logic [1:0]       state_reg;
    logic [CNTW-1:0]  cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [OPW-1:0]   op_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_out_reg;
    logic [3:0]       rsp_flags_reg;
    logic [3:0]       status_reg;
    logic [3:0]       flags_in;
    logic             accept;

    // Accepting in RESP while the response drains gives back-to-back issue with no idle bubble.
    assign req_ready = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign busy      = (state_reg != IDLE);
    assign flags_in  = pack_flags(ula_zero, ula_overflow, ula_carry, ula_neg);

    assign ula_A        = a_reg;
    assign ula_B        = b_reg;
    assign ula_opcode   = op_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_out      = rsp_out_reg;
    assign rsp_flags    = rsp_flags_reg;
    assign status_flags = status_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_out_reg   <= '0;
            rsp_flags_reg <= '0;
            status_reg    <= '0;
        end else begin
            // Operands stay on the ULA after completion; only a new accept replaces them.
            if (accept) begin
                a_reg   <= req_a;
                b_reg   <= req_b;
                op_reg  <= req_op;
                cnt_reg <= CNT_LOAD;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg == '0) begin
                        rsp_out_reg   <= ula_out;
                        rsp_flags_reg <= flags_in;
                        status_reg    <= flags_in;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_dispatch.sv
// Bench for ula_dispatch: two instances (ULA_LAT=1 and ULA_LAT=3) each driving a behavioural ULA,
// with queue scoreboards fed at request acceptance and drained by response monitors.
module tb_ula_dispatch;
    import ula_pkg::*;

    typedef struct {
        logic [35:0] exp;
        int          acc;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rmode = 1'b0;
    int rise_last1 = 0;
    int rise_prev1 = 0;
    int age3 = 100;
    txn_t q1[$];
    txn_t q3[$];

    // instance with ULA_LAT=1
    logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [31:0] req_a, req_b, ula_A, ula_B, ula_out, rsp_out;
    logic [4:0]  req_op, ula_opcode;
    logic        ula_zero, ula_overflow, ula_carry, ula_neg;
    logic [3:0]  rsp_flags, status_flags;
    logic [35:0] r1;

    // instance with ULA_LAT=3
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, busy3;
    logic [31:0] req_a3, req_b3, ula_A3, ula_B3, ula_out3, rsp_out3;
    logic [4:0]  req_op3, ula_opcode3;
    logic        ula_zero3, ula_overflow3, ula_carry3, ula_neg3;
    logic [3:0]  rsp_flags3, status_flags3;
    logic [35:0] r3;

    // Behavioural ULA: {neg, carry, overflow, zero, out} from bit-level arithmetic.
    function automatic logic [35:0] ula_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] op);
        logic [32:0] s;
        logic [31:0] o;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                o = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (o[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                o = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (o[31] != a[31]);
            end
            OP_AND:  o = a & b;
            OP_OR:   o = a | b;
            OP_XOR:  o = a ^ b;
            default: o = a;
        endcase
        return {o[31], c, v, (o == 32'd0), o};
    endfunction

    // Reference model: wide integer arithmetic, overflow as "result outside 32-bit signed range".
    function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op);
        longint ua, ub, sa, sb, ur, sr;
        logic [31:0] o;
        logic c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        o  = a;
        if (op == OP_ADD) begin
            ur = ua + ub;
            sr = sa + sb;
            c  = ur > 64'sd4294967295;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            o  = 32'(ur);
        end else if (op == OP_SUB) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = ua < ub;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            o  = 32'(ur);
        end else if (op == OP_AND) begin
            o = a & b;
        end else if (op == OP_OR) begin
            o = a | b;
        end else if (op == OP_XOR) begin
            o = a ^ b;
        end
        return {o[31], c, v, (o == 32'd0), o};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rnd_op();
        int r;
        r = $urandom_range(0, 7);
        if (r < 5) return 5'(r);
        return 5'($urandom_range(5, 31));
    endfunction

    assign r1 = ula_calc(ula_A, ula_B, ula_opcode);
    assign {ula_neg, ula_carry, ula_overflow, ula_zero, ula_out} = r1;
    // Slow ULA: output is garbage until ULA_LAT-1 edges after new operands.
    assign r3 = (age3 < 2) ? ~ula_calc(ula_A3, ula_B3, ula_opcode3)
                           : ula_calc(ula_A3, ula_B3, ula_opcode3);
    assign {ula_neg3, ula_carry3, ula_overflow3, ula_zero3, ula_out3} = r3;

    ula_dispatch #(.WIDTH(32), .OPW(5), .ULA_LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .ula_A(ula_A), .ula_B(ula_B), .ula_opcode(ula_opcode),
        .ula_out(ula_out), .ula_zero(ula_zero), .ula_overflow(ula_overflow),
        .ula_carry(ula_carry), .ula_neg(ula_neg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags),
        .status_flags(status_flags), .busy(busy)
    );

    ula_dispatch #(.WIDTH(32), .OPW(5), .ULA_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .ula_A(ula_A3), .ula_B(ula_B3), .ula_opcode(ula_opcode3),
        .ula_out(ula_out3), .ula_zero(ula_zero3), .ula_overflow(ula_overflow3),
        .ula_carry(ula_carry3), .ula_neg(ula_neg3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_out(rsp_out3), .rsp_flags(rsp_flags3),
        .status_flags(status_flags3), .busy(busy3)
    );

    // Edge process: scoreboard push on request handshake, pop on response handshake.
    initial begin : edge_proc
        txn_t t;
        forever begin
            @(posedge clock);
            if (!reset) begin
                if (rsp_valid && rsp_ready && q1.size() > 0) void'(q1.pop_front());
                if (req_valid && req_ready) begin
                    t.exp = ref_model(req_a, req_b, req_op);
                    t.acc = cyc;
                    q1.push_back(t);
                end
                if (rsp_valid3 && rsp_ready3 && q3.size() > 0) void'(q3.pop_front());
                if (req_valid3 && req_ready3) begin
                    t.exp = ref_model(req_a3, req_b3, req_op3);
                    t.acc = cyc;
                    q3.push_back(t);
                    age3 = 0;
                end else if (age3 < 100) begin
                    age3 = age3 + 1;
                end
            end
            cyc++;
        end
    end

    initial begin : mon1
        bit pv;
        pv = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && rsp_valid && !pv) begin
                if (q1.size() == 0) begin
                    chk("unexpected_rsp1", rsp_valid, 0);
                end else begin
                    chk("latency1", cyc - 1 - q1[0].acc, 1);
                    chk("rsp_out1", rsp_out, q1[0].exp[31:0]);
                    chk("rsp_flags1", rsp_flags, q1[0].exp[35:32]);
                    chk("status1", status_flags, q1[0].exp[35:32]);
                end
                rise_prev1 = rise_last1;
                rise_last1 = cyc;
            end else if (!reset && rsp_valid && q1.size() > 0) begin
                chk("hold_out1", rsp_out, q1[0].exp[31:0]);
                chk("hold_flags1", rsp_flags, q1[0].exp[35:32]);
            end
            pv = rsp_valid;
        end
    end

    initial begin : mon3
        bit pv;
        pv = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && rsp_valid3 && !pv) begin
                if (q3.size() == 0) begin
                    chk("unexpected_rsp3", rsp_valid3, 0);
                end else begin
                    chk("latency3", cyc - 1 - q3[0].acc, 3);
                    chk("rsp_out3", rsp_out3, q3[0].exp[31:0]);
                    chk("rsp_flags3", rsp_flags3, q3[0].exp[35:32]);
                    chk("status3", status_flags3, q3[0].exp[35:32]);
                end
            end
            pv = rsp_valid3;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        #1;
        while (!req_ready && n < 60) begin
            @(negedge clock);
            if (rmode) rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        chk("req_accept1", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        if (rmode) rsp_ready = ($urandom_range(0, 3) != 0);
        $display("[TB] lat1 req a=%08h b=%08h op=%02h waited=%0d", a, b, op, n);
    endtask

    task automatic send3(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int n;
        n = 0;
        req_valid3 = 1'b1;
        req_a3     = a;
        req_b3     = b;
        req_op3    = op;
        #1;
        while (!req_ready3 && n < 60) begin
            @(negedge clock);
            if (rmode) rsp_ready3 = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        chk("req_accept3", req_ready3, 1);
        @(negedge clock);
        req_valid3 = 1'b0;
        if (rmode) rsp_ready3 = ($urandom_range(0, 3) != 0);
        $display("[TB] lat3 req a=%08h b=%08h op=%02h waited=%0d", a, b, op, n);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int j;
        req_valid = 0; req_a = 0; req_b = 0; req_op = 0; rsp_ready = 0;
        req_valid3 = 0; req_a3 = 0; req_b3 = 0; req_op3 = 0; rsp_ready3 = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ula_A", ula_A, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_status", status_flags, 0);
        @(negedge clock);

        // Directed results
        rsp_ready = 1'b1;
        send(32'h00000001, 32'h7FFFFFFE, OP_ADD);
        @(negedge clock); #1;
        chk("c1_valid", rsp_valid, 1);
        chk("c1_out", rsp_out, 32'h7FFFFFFF);
        chk("c1_flags", rsp_flags, 4'b0000);
        @(negedge clock);
        send(32'h7FFFFFFF, 32'h00000001, OP_ADD);
        @(negedge clock); #1;
        chk("c2_out", rsp_out, 32'h80000000);
        chk("c2_flags", rsp_flags, 4'b1010);
        chk("c2_status", status_flags, 4'b1010);
        @(negedge clock);
        send(32'hFFFFFFFF, 32'h00000001, OP_ADD);
        @(negedge clock); #1;
        chk("c3_out", rsp_out, 32'h00000000);
        chk("c3_flags", rsp_flags, 4'b0101);
        @(negedge clock); #1;
        chk("c3_idle_busy", busy, 0);
        chk("c3_ula_A_kept", ula_A, 32'hFFFFFFFF);
        @(negedge clock);

        // Back-to-back issue: responses two cycles apart with no idle in between
        send(32'h00000001, 32'h7FFFFFFE, OP_ADD);
        send(32'h7FFFFFFF, 32'h00000001, OP_ADD);
        #1;
        chk("b2b_busy", busy, 1);
        @(negedge clock); #1;
        chk("b2b_out", rsp_out, 32'h80000000);
        chk("b2b_spacing", rise_last1 - rise_prev1, 2);
        @(negedge clock);

        // Response held under backpressure while the requester wiggles its inputs
        rsp_ready = 1'b0;
        send(32'h00000001, 32'h7FFFFFFE, OP_ADD);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_a = $urandom;
            req_b = $urandom;
            #1;
            chk("hold_req_ready", req_ready, 0);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_out", rsp_out, 32'h7FFFFFFF);
            chk("hold_rsp_flags", rsp_flags, 4'b0000);
            chk("hold_ula_A", ula_A, 32'h00000001);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        send(32'h7FFFFFFF, 32'h00000001, OP_ADD);
        #1;
        chk("c5_valid_drop", rsp_valid, 0);
        chk("c5_busy", busy, 1);
        @(negedge clock); #1;
        chk("c5_valid", rsp_valid, 1);
        chk("c5_out", rsp_out, 32'h80000000);
        @(negedge clock);

        // Reset in the middle of EXEC drops the operation
        send(32'h12345678, 32'h00000001, OP_SUB);
        #2;
        reset = 1'b1;
        q1.delete();
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ula_A", ula_A, 0);
        chk("mid_rst_status", status_flags, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_ready", req_ready, 1);
        @(negedge clock);

        // Random traffic with random backpressure
        rmode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(rnd_val(), rnd_val(), rnd_op());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clock);
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
        rmode = 1'b0;
        rsp_ready = 1'b1;
        j = 0;
        while (q1.size() > 0 && j < 20) begin
            @(negedge clock);
            j++;
        end
        chk("drain1", q1.size(), 0);
        @(negedge clock);

        // Slow-ULA instance: directed latency, mid-EXEC reset, then random traffic
        rsp_ready3 = 1'b1;
        send3(32'h7FFFFFFF, 32'h00000001, OP_ADD);
        #1;
        j = 0;
        while (!rsp_valid3 && j < 10) begin
            @(negedge clock); #1;
            j++;
        end
        chk("lat3_cycles", j, 3);
        chk("lat3_out", rsp_out3, 32'h80000000);
        chk("lat3_flags", rsp_flags3, 4'b1010);
        @(negedge clock);
        send3(32'h0000000F, 32'h00000003, OP_AND);
        @(negedge clock);
        #2;
        reset = 1'b1;
        q3.delete();
        #1;
        chk("mid_rst3_valid", rsp_valid3, 0);
        chk("mid_rst3_busy", busy3, 0);
        chk("mid_rst3_ula_A", ula_A3, 0);
        chk("mid_rst3_status", status_flags3, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        chk("post_rst3_valid", rsp_valid3, 0);
        @(negedge clock);
        rmode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send3(rnd_val(), rnd_val(), rnd_op());
        end
        rmode = 1'b0;
        rsp_ready3 = 1'b1;
        j = 0;
        while (q3.size() > 0 && j < 30) begin
            @(negedge clock);
            j++;
        end
        chk("drain3", q3.size(), 0);
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
